// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The FSM encoding and the RVC decode helper live here so the top and bench agree.
package inst_fetch_queue_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST        = 32'h0000_0033;
    localparam logic [1:0]  RVC_OPCODE_MASK = 2'b11;

    // A halfword starts a 16-bit instruction unless both opcode low bits are set.
    function automatic logic is_compressed(input logic [1:0] opc);
        return (opc & RVC_OPCODE_MASK) != RVC_OPCODE_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_hw_fifo.sv
// Circular halfword buffer: push/pop of 0, 1 or 2 entries per cycle, two-entry peek,
// occupancy count and a synchronous flush that wins over any same-cycle push/pop.
module hw_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic [1:0]    i_push_n,
    input  logic [15:0]   i_push_hw0,
    input  logic [15:0]   i_push_hw1,
    input  logic [1:0]    i_pop_n,
    output logic [15:0]   o_head0,
    output logic [15:0]   o_head1,
    output logic [CW-1:0] o_count
);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_ptr1;
    logic [AW-1:0] w_rd_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    assign w_rd_ptr1 = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push_n);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop_n);
            r_count  <= r_count + CW'(i_push_n) - CW'(i_pop_n);
        end
    end

    // Storage needs no reset: entries are only observed below the count.
    always_ff @(posedge clk) begin
        if (rst && !i_flush) begin
            if (i_push_n != 2'd0) r_mem[r_wr_ptr]  <= i_push_hw0;
            if (i_push_n == 2'd2) r_mem[w_wr_ptr1] <= i_push_hw1;
        end
    end

    assign o_head0 = r_mem[r_rd_ptr];
    assign o_head1 = r_mem[w_rd_ptr1];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues word reads, buffers halfwords, presents one aligned
// 16/32-bit instruction per cycle, and drains stale responses after a redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic        dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic          r_active;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_head_pc;
    logic          r_skip_low;

    logic          w_grant;
    logic          w_rsp;
    logic [OW-1:0] w_out_next;
    logic [15:0]   w_head0;
    logic [15:0]   w_head1;
    logic [CW-1:0] w_count;
    logic [31:0]   w_free_hw;
    logic          w_can_req;
    logic          w_is_c;
    logic          w_valid;
    logic          w_consume;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;

    hw_fifo #(.DEPTH(DEPTH)) u_hw_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect),
        .i_push_n   (w_push_n),
        .i_push_hw0 (r_skip_low ? mem_rdata[31:16] : mem_rdata[15:0]),
        .i_push_hw1 (mem_rdata[31:16]),
        .i_pop_n    (w_pop_n),
        .o_head0    (w_head0),
        .o_head1    (w_head1),
        .o_count    (w_count)
    );

    // Responses with nothing outstanding belong to requests from before a reset.
    assign w_grant    = mem_req && mem_gnt;
    assign w_rsp      = mem_rvalid && (r_outstanding != OW'(0));
    assign w_out_next = r_outstanding + OW'(w_grant) - OW'(w_rsp);

    // Every outstanding read reserves two halfwords, so the queue can never overflow.
    assign w_free_hw = 32'(DEPTH) - 32'(w_count);
    assign w_can_req = (w_free_hw >= ((32'(r_outstanding) << 1) + 32'd2))
                    && (32'(r_outstanding) < 32'(MAX_OUT));

    assign w_is_c    = is_compressed(w_head0[1:0]);
    assign w_valid   = (w_count >= CW'(2)) || ((w_count == CW'(1)) && w_is_c);
    assign w_consume = w_valid && !stall && !redirect;
    assign w_pop_n   = w_consume ? (w_is_c ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_n  = (r_state == ST_FETCH && w_rsp && !redirect)
                     ? (r_skip_low ? 2'd1 : 2'd2) : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_FETCH;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (redirect)
            w_next_state = (w_out_next != OW'(0)) ? ST_DRAIN : ST_FETCH;
        else if (r_state == ST_DRAIN && w_rsp && r_drop_cnt == OW'(1))
            w_next_state = ST_FETCH;
    end

    // r_active holds requests off until the first edge out of reset.
    always_comb begin
        mem_req   = r_active && (r_state == ST_FETCH) && w_can_req;
        mem_addr  = r_fetch_addr & ~32'd3;
        dbg_state = (r_state == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active      <= 1'b0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fetch_addr  <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_skip_low    <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_out_next;
            if (redirect) begin
                r_fetch_addr <= redirect_pc & ~32'd3;
                r_head_pc    <= redirect_pc & ~32'd1;
                r_skip_low   <= redirect_pc[1];
                r_drop_cnt   <= w_out_next;
            end else begin
                if (w_grant) r_fetch_addr <= r_fetch_addr + 32'd4;
                if (w_push_n != 2'd0) r_skip_low <= 1'b0;
                if (r_state == ST_DRAIN && w_rsp) r_drop_cnt <= r_drop_cnt - OW'(1);
                if (w_consume) r_head_pc <= r_head_pc + (w_is_c ? 32'd2 : 32'd4);
            end
        end
    end

    assign inst_valid = w_valid;
    assign inst       = !w_valid ? NOP_INST
                      : (w_is_c ? {16'h0000, w_head0} : {w_head1, w_head0});
    assign inst_pc    = r_head_pc;
    assign inst_is_c  = w_valid && w_is_c;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with random grant/latency and a
// reference that walks the instruction stream straight from the memory image.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_arr [256];
    int          gnt_mode = 0;  // 0 always grant, 1 random, 2 never
    int          lat_min = 0;
    int          lat_max = 0;
    int          mem_cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] gnt_log[$];

    logic [64:0] exp_q[$];      // {is_c, pc, inst}
    logic [31:0] gen_pc;
    logic [31:0] last_inst;
    logic [31:0] last_pc;
    logic        last_c;
    int          n_consumed = 0;

    inst_fetch_queue #(.DEPTH(8), .RESET_PC(RESET_PC), .MAX_OUT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_is_c   (inst_is_c),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Grants are recorded mid-cycle; responses appear in order, at least one cycle later.
    always begin : memory_model
        int d;
        @(negedge clk);
        if (mem_req && mem_gnt) begin
            d = mem_cyc + 1 + int'($urandom_range(lat_max, lat_min));
            if (pend_due.size() > 0 && d < pend_due[$]) d = pend_due[$];
            pend_addr.push_back(mem_addr);
            pend_due.push_back(d);
            gnt_log.push_back(mem_addr);
        end
        @(posedge clk);
        #1;
        mem_cyc++;
        if (pend_due.size() > 0 && pend_due[0] <= mem_cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_arr[pend_addr[0][9:2]];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 3) != 0);
            default: mem_gnt = 1'b0;
        endcase
    end

    function automatic logic [15:0] hw_at(input logic [31:0] p);
        logic [31:0] w;
        w = mem_arr[p[9:2]];
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic top_up();
        logic [15:0] h0;
        while (exp_q.size() < 16) begin
            h0 = hw_at(gen_pc);
            if (h0[1:0] != 2'b11) begin
                exp_q.push_back({1'b1, gen_pc, 16'h0000, h0});
                gen_pc = gen_pc + 32'd2;
            end else begin
                exp_q.push_back({1'b0, gen_pc, hw_at(gen_pc + 32'd2), h0});
                gen_pc = gen_pc + 32'd4;
            end
        end
    endtask

    task automatic gen_expected(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
        top_up();
    endtask

    // One clock: drive this cycle's inputs, then score whatever the DUT presents.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic stl);
        logic [64:0] e;
        @(posedge clk);
        #2;
        redirect    = redir;
        redirect_pc = rpc;
        stall       = stl;
        if (!rst) begin
        end else if (redir) begin
            gen_expected(rpc & ~32'd1);
        end else if (inst_valid && !stl) begin
            n_checks++;
            e = exp_q.pop_front();
            if ({inst_is_c, inst_pc, inst} !== e) begin
                n_errors++;
                $display("FAIL stream: got c=%0b pc=%h inst=%h, expected c=%0b pc=%h inst=%h",
                         inst_is_c, inst_pc, inst, e[64], e[63:32], e[31:0]);
            end
            last_inst = inst;
            last_pc   = inst_pc;
            last_c    = inst_is_c;
            n_consumed++;
            top_up();
        end else if (!inst_valid) begin
            n_checks++;
            if (inst !== NOP_INST || inst_is_c !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_nop: got inst=%h c=%0b, expected inst=%h c=0",
                         inst, inst_is_c, NOP_INST);
            end
        end
    endtask

    task automatic wait_consumes(input int n, input string name);
        int target;
        int budget;
        target = n_consumed + n;
        budget = 200;
        while (n_consumed < target && budget > 0) begin
            step(1'b0, 32'h0, 1'b0);
            budget--;
        end
        if (n_consumed < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d consumed, expected %0d", name, n_consumed, target);
        end
    endtask

    task automatic test_reset();
        int first_cyc;
        rst = 1'b0;
        gnt_mode = 0; lat_min = 0; lat_max = 0;
        mem_arr[0] = 32'h00A00093;
        repeat (3) step(1'b0, 32'h0, 1'b0);
        n_checks++;
        if ({mem_req, mem_addr, inst_valid, inst, inst_pc, inst_is_c, dbg_state}
            !== {1'b0, RESET_PC, 1'b0, NOP_INST, RESET_PC, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got req=%0b addr=%h v=%0b inst=%h pc=%h c=%0b st=%0b, expected 0 %h 0 %h %h 0 0",
                     mem_req, mem_addr, inst_valid, inst, inst_pc, inst_is_c, dbg_state,
                     RESET_PC, NOP_INST, RESET_PC);
        end
        rst = 1'b1;
        gen_expected(RESET_PC);
        first_cyc = 0;
        for (int k = 1; k <= 6 && first_cyc == 0; k++) begin
            step(1'b0, 32'h0, 1'b0);
            if (inst_valid) first_cyc = k;
        end
        n_checks++;
        if (first_cyc != 3 || inst !== 32'h00A00093 || inst_pc !== 32'h0 || inst_is_c !== 1'b0) begin
            n_errors++;
            $display("FAIL first_fetch: got cycle=%0d inst=%h pc=%h c=%0b, expected cycle=3 inst=00a00093 pc=0 c=0",
                     first_cyc, inst, inst_pc, inst_is_c);
        end
    endtask

    task automatic test_mixed();
        mem_arr[0] = 32'h00934501;
        mem_arr[1] = 32'hABCD0093;
        step(1'b1, 32'h0, 1'b0);
        wait_consumes(1, "mixed0");
        n_checks++;
        if ({last_c, last_pc, last_inst} !== {1'b1, 32'h0, 32'h00004501}) begin
            n_errors++;
            $display("FAIL mixed_c: got c=%0b pc=%h inst=%h, expected c=1 pc=0 inst=00004501",
                     last_c, last_pc, last_inst);
        end
        wait_consumes(1, "mixed1");
        n_checks++;
        if ({last_c, last_pc, last_inst} !== {1'b0, 32'h2, 32'h00930093}) begin
            n_errors++;
            $display("FAIL mixed_32: got c=%0b pc=%h inst=%h, expected c=0 pc=2 inst=00930093",
                     last_c, last_pc, last_inst);
        end
    endtask

    task automatic test_redirect_drain();
        int budget;
        mem_arr[8'h40] = 32'h4505_1234;
        gnt_mode = 0; lat_min = 3; lat_max = 3;
        step(1'b1, 32'h0, 1'b0);
        budget = 30;
        do begin
            step(1'b0, 32'h0, 1'b0);
            budget--;
        end while (!(pend_addr.size() == 2 && !mem_rvalid) && budget > 0);
        step(1'b1, 32'h0000_0102, 1'b0);
        gnt_log.delete();
        step(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (dbg_state !== 1'b1 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_enter: got state=%0b req=%0b, expected state=1 req=0", dbg_state, mem_req);
        end
        budget = 30;
        while (gnt_log.size() == 0 && budget > 0) begin
            step(1'b0, 32'h0, 1'b0);
            budget--;
        end
        n_checks++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 32'h100) begin
            n_errors++;
            $display("FAIL drain_addr: got %0d grants first=%h, expected first grant at 00000100",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 32'hx);
        end
        wait_consumes(1, "drain_head");
        n_checks++;
        if ({last_c, last_pc, last_inst} !== {1'b1, 32'h102, 32'h00004505}) begin
            n_errors++;
            $display("FAIL drain_head: got c=%0b pc=%h inst=%h, expected c=1 pc=102 inst=00004505",
                     last_c, last_pc, last_inst);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rec_inst;
        logic [31:0] rec_pc;
        gnt_mode = 0; lat_min = 0; lat_max = 0;
        step(1'b1, 32'h200, 1'b1);
        repeat (20) step(1'b0, 32'h0, 1'b1);
        rec_inst = inst;
        rec_pc   = inst_pc;
        n_checks++;
        if (rec_pc !== 32'h200 || inst_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_head: got pc=%h v=%0b, expected pc=00000200 v=1", rec_pc, inst_valid);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++;
            if (mem_req !== 1'b0 || inst !== rec_inst || inst_pc !== rec_pc) begin
                n_errors++;
                $display("FAIL stall_hold: got req=%0b inst=%h pc=%h, expected req=0 inst=%h pc=%h",
                         mem_req, inst, inst_pc, rec_inst, rec_pc);
            end
        end
        wait_consumes(8, "stall_release");
    endtask

    task automatic test_gnt_holdoff();
        logic [31:0] rec_addr;
        int budget;
        gnt_mode = 0; lat_min = 0; lat_max = 0;
        step(1'b1, 32'h80, 1'b0);
        gnt_mode = 2;
        repeat (2) step(1'b0, 32'h0, 1'b0);
        budget = 40;
        while (!mem_req && budget > 0) begin
            step(1'b0, 32'h0, 1'b0);
            budget--;
        end
        rec_addr = mem_addr;
        n_checks++;
        if (mem_req !== 1'b1 || rec_addr[1:0] !== 2'b00) begin
            n_errors++;
            $display("FAIL holdoff_start: got req=%0b addr=%h, expected req=1 word-aligned", mem_req, rec_addr);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, 1'b0);
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== rec_addr) begin
                n_errors++;
                $display("FAIL holdoff_hold: got req=%0b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, rec_addr);
            end
        end
        gnt_mode = 0;
        wait_consumes(6, "holdoff_release");
    endtask

    task automatic test_reset_midflight();
        int budget;
        gnt_mode = 0; lat_min = 4; lat_max = 4;
        step(1'b1, 32'h300, 1'b0);
        budget = 20;
        while (pend_addr.size() == 0 && budget > 0) begin
            step(1'b0, 32'h0, 1'b0);
            budget--;
        end
        gnt_mode = 2;
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        gen_expected(RESET_PC);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 32'h0, 1'b0);
            n_checks++;
            if (inst_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL late_rsp: got inst_valid=%0b pc=%h, expected queue empty", inst_valid, inst_pc);
            end
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || inst_pc !== RESET_PC) begin
            n_errors++;
            $display("FAIL restart: got req=%0b addr=%h pc=%h, expected req=1 addr=%h pc=%h",
                     mem_req, mem_addr, inst_pc, RESET_PC, RESET_PC);
        end
        gnt_mode = 0; lat_min = 0; lat_max = 0;
        wait_consumes(1, "restart");
        n_checks++;
        if (last_pc !== RESET_PC) begin
            n_errors++;
            $display("FAIL restart_pc: got %h, expected %h", last_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] rpc;
        logic        stl;
        gnt_mode = 1; lat_min = 0; lat_max = 3;
        for (int k = 0; k < 1500; k++) begin
            redir = ($urandom_range(0, 99) < 4);
            rpc   = 32'($urandom_range(0, 1023));
            stl   = ($urandom_range(0, 99) < 30);
            step(redir, rpc, stl);
        end
        gnt_mode = 0;
        wait_consumes(4, "random_tail");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        test_reset();
        test_mixed();
        test_redirect_drain();
        test_stall();
        test_gnt_holdoff();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
